// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requester and a small instruction buffer.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count/stall_count outputs.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count,
`endif
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int unsigned     PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CntW  = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    outstanding_q, outstanding_d;
    logic                    discard_q, discard_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem_q   [FIFO_DEPTH];

    logic                    accept;
    logic                    resp;
    logic                    push;
    logic                    pop;
    logic                    slot_free;
    logic [CntW-1:0]         occupancy;

    assign instr_valid = (count_q != '0);
    assign instruction = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign imem_addr   = pc_q;

    assign pop  = instr_valid && instr_ready && !redirect;
    assign resp = imem_rvalid && outstanding_q;
    assign push = resp && !discard_q && !redirect;

    // A returning response frees the single request slot in the same cycle; the credit
    // counts it as buffered, and a same-cycle pop returns one entry of credit.
    assign slot_free = !outstanding_q || imem_rvalid;
    assign occupancy = count_q + CntW'(outstanding_q) - CntW'(pop);
    assign imem_req  = (state_q == StFetch) && !redirect && slot_free && (occupancy < Depth);
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (!start) state_d = StDrain;
            StDrain: begin
                if (start) begin
                    state_d = StFetch;
                end else if (!outstanding_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q + PtrW'(pop);
        wr_ptr_d      = wr_ptr_q + PtrW'(push);
        count_d       = count_q + CntW'(push) - CntW'(pop);

        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        if (accept) begin
            outstanding_d = 1'b1;
            discard_d     = 1'b0;
            req_addr_d    = pc_q;
            pc_d          = pc_q + ADDR_WIDTH'(1);
        end
        // Redirect never coincides with accept because imem_req is withdrawn.
        if (redirect) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (outstanding_q && !imem_rvalid) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_addr_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == StFetch) && !instr_valid && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
